ov7670_sccb_init: RTL and testbench
===================================

# ov7670_sccb_init

Power-up configuration sequencer for the OV7670 camera. It sits upstream of the pixel capture and framebuffer path. After reset it reads (register, value) pairs from a table ROM and writes each one to the sensor over the 3-wire SCCB write protocol (SIO_C/SIO_D). The sensor then drives pclk/vsync/href/data in the RGB format the capture stage expects. It raises `done` once the table terminator is reached; the capture path is held off until then.

## Interface

Parameters:
- CLK_DIV, 68: clk27 cycles per SCCB quarter-bit (68 → ~99 kHz SIO_C).
- DEV_ADDR, 8'h42: SCCB write ID of the sensor.
- POWERUP_WAIT, 27000: clk27 cycles idle after reset before the first transaction (1 ms).
- DELAY_CYCLES, 27000: wait inserted by a delay table entry.
- GAP_CYCLES, 270: bus-idle cycles between transactions.

Ports (clock and reset first):
- clk27  in  1  system clock; all logic on rising edge.
- clr  in  1  asynchronous, active-low reset.
- rom_addr  out  8  table index.
- rom_data  in  16  table entry, {reg[15:8], value[7:0]}; synchronous ROM, valid 1 cycle after rom_addr changes.
- sioc  out  1  SCCB clock.
- siod_out  out  1  SCCB data value.
- siod_oe  out  1  SCCB data output enable; external tristate.
- busy  out  1  sequence in progress.
- done  out  1  table complete; sticky until reset.

## Operation

- Reset values: sioc=1, siod_out=1, siod_oe=1, rom_addr=0, busy=0, done=0. State is WAIT_PWR, with the counters cleared.
- WAIT_PWR: busy=1 from the first cycle after clr deasserts. Count POWERUP_WAIT cycles, then go to FETCH.
- FETCH: hold rom_addr, wait 1 cycle, then latch rom_data and go to DECODE.
- DECODE:
  - 16'hFFFF is the terminator → DONE.
  - 16'hFFF0 is a delay entry → DELAY.
  - Any other value → START.
- START, 4 quarters:
  - q0–q1: sioc=1, siod=1.
  - q2: siod=0.
  - q3: sioc=0.
- BITS: 27 bits in three phases, in order DEV_ADDR, reg, value. Each phase is 8 bits MSB-first plus a 9th don't-care bit.
  - Per bit: q0 sioc=0 and siod updated; q1 sioc=0; q2–q3 sioc=1.
  - During each 9th bit, siod_oe=0; the sensor is not monitored.
- STOP, 4 quarters:
  - q0: sioc=0, siod_oe=1, siod=0.
  - q1: sioc=1.
  - q2–q3: siod=1.
- GAP: bus idle (sioc=1, siod=1) for GAP_CYCLES. Then rom_addr+1 → FETCH.
- DELAY: bus idle for DELAY_CYCLES. Then rom_addr+1 → FETCH.
- DONE: done=1, busy=0, bus idle, rom_addr frozen. Stays here until reset.
- rom_addr wraps 255→0 only if the table has no terminator; sequencing continues after the wrap. The table must contain a terminator.
- clr asserted mid-transaction aborts immediately: outputs return to reset values (bus idle). After release, the sequence restarts at entry 0 with the full power-up wait.

## Timing

- Quarter tick: a divider counts 0..CLK_DIV-1 and pulses on the terminal count. All SCCB output changes occur on the clk27 edge of a tick.
- One write transaction = (4 + 27×4 + 4) × CLK_DIV = 116×CLK_DIV cycles, plus GAP_CYCLES.
- Fetch overhead: 2 cycles per entry (FETCH, DECODE).
- Outputs are registered; no combinational path from rom_data to the pins.
- done rises in the cycle busy falls.

## Test plan

- Reset behaviour: CLK_DIV=4, POWERUP_WAIT=10, ROM {12'h80 at 0, FFFF at 1}. Hold clr low → sioc=1, siod_out=1, siod_oe=1, busy=0. After release: busy=1 next cycle; first siod fall at cycle 10+2+2×4.
- Single write: same setup. The bus model decodes ID 0x42, reg 0x12, value 0x80. siod_oe=0 during bits 9/18/27. SIO_C period = 16 cycles. done=1 after 116×4+GAP_CYCLES+fetch cycles; busy=0.
- Delay entry: ROM {FFF0, 1100, FFFF} with DELAY_CYCLES=50 → no SIO_C edges for 50 cycles, then write reg 0x11 value 0x00, then done.
- Multi-entry table: 3 writes → three transactions in order with ≥GAP_CYCLES idle between each stop and the next start. rom_addr ends at 3.
- Reset mid-transaction: assert clr during bit 14 of the first write → outputs return to reset values within the same cycle (async). After release, rom_addr=0 and the sequence restarts from the power-up wait.
- Terminator first: ROM {FFFF} → no SIO_C activity. done=1 at POWERUP_WAIT+2 cycles after reset release.

Source files
------------

// File: rtl/ov7670_sccb_init.sv
// OV7670 power-up sequencer: walks a (reg, value) table ROM and issues one
// 3-phase SCCB write per entry, with delay entries and a terminator.
module ov7670_sccb_init #(
    parameter int         CLK_DIV      = 68,
    parameter logic [7:0] DEV_ADDR     = 8'h42,
    parameter int         POWERUP_WAIT = 27000,
    parameter int         DELAY_CYCLES = 27000,
    parameter int         GAP_CYCLES   = 270
) (
    input  logic        clk27,
    input  logic        clr,
    output logic [7:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic        sioc,
    output logic        siod_out,
    output logic        siod_oe,
    output logic        busy,
    output logic        done
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [3:0] {
        WAIT_PWR, FETCH, DECODE, START, BITS, STOP, GAP, DELAY, DONE
    } state_t;

    state_t        state_reg;
    logic [31:0]   cnt_reg;
    logic [DW-1:0] div_reg;
    logic [1:0]    qtr_reg;
    logic [3:0]    bitn_reg;
    logic [1:0]    byte_reg;
    logic [26:0]   sh_reg;
    logic [7:0]    addr_reg;
    logic          sioc_reg, siod_reg, oe_reg, busy_reg, done_reg;
    logic          tick;

    assign tick     = (div_reg == DW'(CLK_DIV - 1));
    assign rom_addr = addr_reg;
    assign sioc     = sioc_reg;
    assign siod_out = siod_reg;
    assign siod_oe  = oe_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;

    always_ff @(posedge clk27 or negedge clr) begin
        if (!clr) begin
            state_reg <= WAIT_PWR;
            cnt_reg   <= '0;
            div_reg   <= '0;
            qtr_reg   <= '0;
            bitn_reg  <= '0;
            byte_reg  <= '0;
            sh_reg    <= '0;
            addr_reg  <= '0;
            sioc_reg  <= 1'b1;
            siod_reg  <= 1'b1;
            oe_reg    <= 1'b1;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            if (state_reg == START || state_reg == BITS || state_reg == STOP)
                div_reg <= tick ? '0 : div_reg + 1'b1;

            case (state_reg)
                WAIT_PWR: begin
                    busy_reg <= 1'b1;
                    if (cnt_reg == 32'(POWERUP_WAIT - 1)) begin
                        cnt_reg   <= '0;
                        state_reg <= FETCH;
                    end else begin
                        cnt_reg <= cnt_reg + 32'd1;
                    end
                end
                // rom_data for the current address is valid once FETCH has elapsed
                FETCH: state_reg <= DECODE;
                DECODE: begin
                    if (rom_data == 16'hFFFF) begin
                        state_reg <= DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end else if (rom_data == 16'hFFF0) begin
                        cnt_reg   <= '0;
                        state_reg <= DELAY;
                    end else begin
                        // Ninth bit of each phase is a don't-care slot, driven high
                        sh_reg    <= {DEV_ADDR, 1'b1, rom_data[15:8], 1'b1, rom_data[7:0], 1'b1};
                        div_reg   <= '0;
                        qtr_reg   <= '0;
                        state_reg <= START;
                    end
                end
                START: if (tick) begin
                    qtr_reg <= qtr_reg + 2'd1;
                    case (qtr_reg)
                        2'd1: siod_reg <= 1'b0;
                        2'd2: sioc_reg <= 1'b0;
                        2'd3: begin
                            state_reg <= BITS;
                            bitn_reg  <= '0;
                            byte_reg  <= '0;
                            siod_reg  <= sh_reg[26];
                            sh_reg    <= sh_reg << 1;
                            oe_reg    <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                BITS: if (tick) begin
                    qtr_reg <= qtr_reg + 2'd1;
                    if (qtr_reg == 2'd1) begin
                        sioc_reg <= 1'b1;
                    end else if (qtr_reg == 2'd3) begin
                        sioc_reg <= 1'b0;
                        if (bitn_reg == 4'd8 && byte_reg == 2'd2) begin
                            state_reg <= STOP;
                            oe_reg    <= 1'b1;
                            siod_reg  <= 1'b0;
                        end else begin
                            siod_reg <= sh_reg[26];
                            sh_reg   <= sh_reg << 1;
                            if (bitn_reg == 4'd8) begin
                                bitn_reg <= '0;
                                byte_reg <= byte_reg + 2'd1;
                                oe_reg   <= 1'b1;
                            end else begin
                                bitn_reg <= bitn_reg + 4'd1;
                                oe_reg   <= (bitn_reg != 4'd7);
                            end
                        end
                    end
                end
                STOP: if (tick) begin
                    qtr_reg <= qtr_reg + 2'd1;
                    case (qtr_reg)
                        2'd0: sioc_reg <= 1'b1;
                        2'd1: siod_reg <= 1'b1;
                        2'd3: begin
                            cnt_reg   <= '0;
                            state_reg <= GAP;
                        end
                        default: ;
                    endcase
                end
                GAP: begin
                    if (cnt_reg == 32'(GAP_CYCLES - 1)) begin
                        addr_reg  <= addr_reg + 8'd1;
                        state_reg <= FETCH;
                    end else begin
                        cnt_reg <= cnt_reg + 32'd1;
                    end
                end
                DELAY: begin
                    if (cnt_reg == 32'(DELAY_CYCLES - 1)) begin
                        addr_reg  <= addr_reg + 8'd1;
                        state_reg <= FETCH;
                    end else begin
                        cnt_reg <= cnt_reg + 32'd1;
                    end
                end
                DONE: ;
                default: state_reg <= WAIT_PWR;
            endcase
        end
    end

endmodule

// File: tb/tb_ov7670_sccb_init.sv
// Directed and randomized tables driven through the sequencer; an SCCB bus
// monitor decodes transactions and timing is checked against a cycle model.
module tb_ov7670_sccb_init;

    localparam int CD = 4, PW = 10, DL = 50, GP = 20;

    logic        clk27 = 1'b0;
    logic        clr   = 1'b1;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic        sioc, siod_out, siod_oe, busy, done;
    logic [15:0] rom [256];
    logic [15:0] ent [$];

    int cyc = 0, rel_cyc = 0;
    int n_assert = 0, n_fail = 0;

    // bus monitor state
    bit          in_txn = 0;
    int          nbits = 0, first_start = -1, first_chg = -1, sioc_chg = 0;
    int          oe_err = 0, oe_low = 0, per_min = 1000000, per_max = 0, last_rise = 0;
    logic [26:0] sh = '0;
    logic        sioc_p = 1'b1, siod_p = 1'b1;
    logic [26:0] txq [$];
    int          start_t [$];
    int          stop_t [$];

    ov7670_sccb_init #(
        .CLK_DIV(CD), .DEV_ADDR(8'h42), .POWERUP_WAIT(PW),
        .DELAY_CYCLES(DL), .GAP_CYCLES(GP)
    ) dut (
        .clk27(clk27), .clr(clr), .rom_addr(rom_addr), .rom_data(rom_data),
        .sioc(sioc), .siod_out(siod_out), .siod_oe(siod_oe), .busy(busy), .done(done)
    );

    always #5 clk27 = ~clk27;
    always @(posedge clk27) rom_data <= rom[rom_addr];
    always @(posedge clk27) cyc <= cyc + 1;

    always @(negedge clk27) begin
        int t;
        t = cyc - rel_cyc;
        if (!clr) begin
            in_txn = 0;
        end else begin
            if (sioc && sioc_p && siod_p && !siod_out) begin
                in_txn = 1;
                nbits  = 0;
                start_t.push_back(t);
                if (first_start < 0) first_start = t;
            end else if (in_txn && sioc && !sioc_p && nbits < 27) begin
                sh = {sh[25:0], siod_out};
                if ((nbits % 9) == 8) begin
                    if (siod_oe) oe_err++; else oe_low++;
                end else if (!siod_oe) begin
                    oe_err++;
                end
                if (nbits > 0) begin
                    if (t - last_rise < per_min) per_min = t - last_rise;
                    if (t - last_rise > per_max) per_max = t - last_rise;
                end
                last_rise = t;
                nbits++;
            end else if (in_txn && sioc && sioc_p && !siod_p && siod_out) begin
                if (nbits == 27) txq.push_back(sh);
                stop_t.push_back(t);
                in_txn = 0;
            end
            if (sioc !== sioc_p) begin
                sioc_chg++;
                if (first_chg < 0) first_chg = t;
            end
        end
        sioc_p = sioc;
        siod_p = siod_out;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Load the table, hold reset (checking idle outputs), then release it.
    task automatic launch();
        for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
        foreach (ent[i]) rom[i] = ent[i];
        clr = 1'b0;
        repeat (3) @(negedge clk27);
        chk("rst_sioc", sioc, 1);
        chk("rst_siod", siod_out, 1);
        chk("rst_oe", siod_oe, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", rom_addr, 0);
        clr = 1'b1;
        rel_cyc = cyc;
        first_start = -1; first_chg = -1; sioc_chg = 0; oe_err = 0; oe_low = 0;
        per_min = 1000000; per_max = 0;
        txq.delete(); start_t.delete(); stop_t.delete();
        @(negedge clk27);
        chk("busy_after_release", busy, 1);
    endtask

    // Model: timing and expected writes derived from the table contents alone.
    task automatic verify(input string name);
        int  exp_done = PW, pre_delay = 0, nw = 0, k = 0, j = 0, t_fs;
        bit  seen_w = 0;
        foreach (ent[i]) begin
            if (ent[i] == 16'hFFF0) begin
                exp_done += 2 + DL;
                if (!seen_w) pre_delay++;
            end else begin
                exp_done += 2 + 116 * CD + GP;
                seen_w = 1;
                nw++;
            end
        end
        exp_done += 2;
        while (done !== 1'b1 && k < exp_done + 100) begin
            @(negedge clk27);
            k++;
        end
        chk({name, "_done_time"}, cyc - rel_cyc, exp_done);
        chk({name, "_busy_end"}, busy, 0);
        chk({name, "_addr_end"}, rom_addr, ent.size());
        repeat (5) @(negedge clk27);
        chk({name, "_done_sticky"}, done, 1);
        chk({name, "_txn_count"}, txq.size(), nw);
        foreach (ent[i]) begin
            if (ent[i] != 16'hFFF0) begin
                if (j < txq.size()) begin
                    $display("%s: write id=%02h reg=%02h val=%02h", name,
                             txq[j][26:19], txq[j][17:10], txq[j][8:1]);
                    chk({name, "_id"}, txq[j][26:19], 8'h42);
                    chk({name, "_reg"}, txq[j][17:10], ent[i][15:8]);
                    chk({name, "_val"}, txq[j][8:1], ent[i][7:0]);
                end
                j++;
            end else begin
                $display("%s: delay entry", name);
            end
        end
        chk({name, "_oe_err"}, oe_err, 0);
        chk({name, "_oe_low"}, oe_low, 3 * nw);
        if (nw > 0) begin
            t_fs = PW + pre_delay * (2 + DL) + 2 + 2 * CD;
            chk({name, "_first_start"}, first_start, t_fs);
            chk({name, "_first_sioc"}, first_chg, t_fs + CD);
            chk({name, "_per_min"}, per_min, 4 * CD);
            chk({name, "_per_max"}, per_max, 4 * CD);
            for (int i = 1; i < start_t.size(); i++)
                if (i - 1 < stop_t.size())
                    chk({name, "_gap"}, (start_t[i] - stop_t[i - 1]) >= GP, 1);
        end else begin
            chk({name, "_no_sioc"}, sioc_chg, 0);
        end
    endtask

    initial begin
        int k;
        #1 clr = 1'b0;

        ent = '{16'h1280};
        launch();
        verify("single");

        ent = '{16'hFFF0, 16'h1100};
        launch();
        verify("delay");

        ent.delete();
        for (int i = 0; i < 3; i++) ent.push_back({8'($urandom_range(0, 254)), 8'($urandom)});
        launch();
        verify("multi");

        ent.delete();
        launch();
        verify("term_first");

        for (int it = 0; it < 3; it++) begin
            int n;
            n = $urandom_range(1, 4);
            ent.delete();
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) ent.push_back(16'hFFF0);
                else ent.push_back({8'($urandom_range(0, 254)), 8'($urandom)});
            end
            launch();
            verify("random");
        end

        ent = '{{8'($urandom_range(0, 254)), 8'($urandom)}};
        launch();
        k = 0;
        while (nbits < 14 && k < 2000) begin
            @(negedge clk27);
            k++;
        end
        chk("mid_reached_bit14", nbits >= 14, 1);
        @(posedge clk27);
        #1 clr = 1'b0;
        #1;
        chk("mid_sioc", sioc, 1);
        chk("mid_siod", siod_out, 1);
        chk("mid_oe", siod_oe, 1);
        chk("mid_busy", busy, 0);
        chk("mid_addr", rom_addr, 0);
        launch();
        verify("mid_restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
